// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - sequences WIDTH-bit add/sub through an external 4-bit adder, LSB nibble first
// Optional subtract support is enabled by defining NSA_SUB_EN.
module nibble_serial_adder #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
`ifdef NSA_SUB_EN
   input  logic             in_sub,
`endif
   output logic [3:0]       adder_a,
   output logic [3:0]       adder_b,
   output logic             adder_cin,
   input  logic [3:0]       adder_sum,
   input  logic             adder_cout,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout
);

   localparam int NIB = WIDTH / 4;
   localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

   typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] res_q;
   logic             carry_q;
   logic [CW-1:0]    nib_cnt;
   logic [WIDTH-1:0] b_load;
   logic             cin_load;

   // Subtraction is a + ~b + 1; the subtract flag only matters at load time.
   always_comb begin
      b_load   = in_b;
      cin_load = in_cin;
`ifdef NSA_SUB_EN
      if (in_sub) begin
         b_load   = ~in_b;
         cin_load = 1'b1;
      end
`endif
   end

   assign adder_a   = (state == RUN) ? a_q[3:0] : 4'd0;
   assign adder_b   = (state == RUN) ? b_q[3:0] : 4'd0;
   assign adder_cin = (state == RUN) ? carry_q  : 1'b0;
   assign out_sum   = res_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_cout  <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         res_q     <= '0;
         carry_q   <= 1'b0;
         nib_cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               in_ready <= 1'b1;
               if (in_valid && in_ready) begin
                  a_q      <= in_a;
                  b_q      <= b_load;
                  carry_q  <= cin_load;
                  nib_cnt  <= '0;
                  res_q    <= '0;
                  out_cout <= 1'b0;
                  in_ready <= 1'b0;
                  state    <= RUN;
               end
            end
            RUN: begin
               // Sum nibbles enter at the top so the result is LSB-aligned after NIB shifts.
               res_q   <= (res_q >> 4) | (WIDTH'(adder_sum) << (WIDTH - 4));
               carry_q <= adder_cout;
               a_q     <= a_q >> 4;
               b_q     <= b_q >> 4;
               nib_cnt <= nib_cnt + 1'b1;
               if (nib_cnt == CW'(NIB - 1)) begin
                  nib_cnt   <= '0;
                  out_valid <= 1'b1;
                  out_cout  <= adder_cout;
                  state     <= HOLD;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
